// File: rtl/lwe_ct_finalize.sv
// lwe_ct_finalize: reduces accumulated row sums mod q, adds msg*DELTA to the body word,
// and streams the results out through a small FIFO over valid/ready.
module lwe_ct_finalize #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 32,
    parameter int Q_WIDTH            = 10,
    parameter int DIMENSION          = 128,
    parameter int DIM_WIDTH          = 8,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [PLAINTEXT_WIDTH-1:0]  msg,
    input  logic                        in_valid,
    input  logic [CIPHERTEXT_WIDTH-1:0] in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [CIPHERTEXT_WIDTH-1:0] out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [Q_WIDTH-1:0] DELTA = Q_WIDTH'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [DIM_WIDTH-1:0] cnt;
    logic [PLAINTEXT_WIDTH-1:0] msg_q;
    logic [Q_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop, is_body;
    logic [Q_WIDTH-1:0] word;
    logic unused_hi;
    assign unused_hi = ^in_data[CIPHERTEXT_WIDTH-1:Q_WIDTH];
    assign in_ready  = (state == RUN) && (count < (AW+1)'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign is_body   = cnt == DIM_WIDTH'(DIMENSION);
    // Reduction mod q is plain truncation; the body add wraps the same way.
    assign word      = in_data[Q_WIDTH-1:0] + (is_body ? Q_WIDTH'(msg_q) * DELTA : '0);
    assign out_data  = out_valid ? CIPHERTEXT_WIDTH'(mem[rd_ptr][Q_WIDTH-1:0]) : '0;
    assign out_last  = out_valid && mem[rd_ptr][Q_WIDTH];
    assign busy      = state != IDLE;
    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = RUN;
        if (state == RUN && push && is_body) state_nx = DRAIN;
        if (state == DRAIN && pop && out_last) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            msg_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt   <= '0;
                msg_q <= msg;
            end else if (push) begin
                cnt <= cnt + DIM_WIDTH'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == RUN && in_valid && !in_ready) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {is_body, word};
    end
endmodule

// File: tb/tb_lwe_ct_finalize.sv
// tb_lwe_ct_finalize: directed checks of lwe_ct_finalize with DIMENSION=4, q=1024, p=64.
module tb_lwe_ct_finalize;
    logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [5:0]  msg = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, out_last, busy, overflow;
    logic [31:0] out_data;
    int total = 0, bad = 0;
    logic [32:0] got [$];

    lwe_ct_finalize #(
        .PLAINTEXT_MODULUS(64), .PLAINTEXT_WIDTH(6), .CIPHERTEXT_MODULUS(1024),
        .CIPHERTEXT_WIDTH(32), .Q_WIDTH(10), .DIMENSION(4), .DIM_WIDTH(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && out_valid && out_ready) got.push_back({out_last, out_data});

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_ct(input logic [5:0] m);
        start = 1;
        msg = m;
        step();
        start = 0;
        msg = 6'h2A;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", 33'(in_ready), 33'd1);
        in_valid = 1;
        in_data = w;
        step();
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("idle", 33'(busy), 33'd0);
        step();
    endtask

    task automatic chk_out(input string tag, input int idx, input logic last, input logic [31:0] d);
        chk(tag, idx < got.size() ? got[idx] : 'x, {last, d});
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 33'(out_valid), 33'd0);
        chk("rst_out_data", 33'(out_data), 33'd0);
        chk("rst_out_last", 33'(out_last), 33'd0);
        chk("rst_in_ready", 33'(in_ready), 33'd0);
        chk("rst_busy", 33'(busy), 33'd0);
        chk("rst_overflow", 33'(overflow), 33'd0);
        rst_n = 1;
        step();
        // basic ciphertext, msg=3 -> body adds 48
        got.delete();
        out_ready = 1;
        begin_ct(3);
        chk("t1_busy", 33'(busy), 33'd1);
        send(32'h401);
        chk("t1_latency", 33'(out_valid), 33'd1);
        send(2); send(3); send(4); send(32'h3FF);
        wait_idle();
        chk("t1_n", 33'(got.size()), 33'd5);
        chk_out("t1_w0", 0, 0, 32'h001);
        chk_out("t1_w1", 1, 0, 32'h002);
        chk_out("t1_w2", 2, 0, 32'h003);
        chk_out("t1_w3", 3, 0, 32'h004);
        chk_out("t1_body", 4, 1, 32'h02F);
        // backpressure: FIFO fills after 4 accepts, head stays put
        got.delete();
        out_ready = 0;
        begin_ct(0);
        send(10); send(11); send(12); send(13);
        chk("t2_full_ready", 33'(in_ready), 33'd0);
        chk("t2_head", 33'(out_data), 33'd10);
        step(); step();
        chk("t2_head_stable", 33'(out_data), 33'd10);
        chk("t2_valid_stable", 33'(out_valid), 33'd1);
        out_ready = 1;
        send(14);
        wait_idle();
        chk("t2_n", 33'(got.size()), 33'd5);
        chk_out("t2_w0", 0, 0, 32'd10);
        chk_out("t2_w1", 1, 0, 32'd11);
        chk_out("t2_w2", 2, 0, 32'd12);
        chk_out("t2_w3", 3, 0, 32'd13);
        chk_out("t2_body", 4, 1, 32'd14);
        chk("t2_overflow", 33'(overflow), 33'd0);
        // wrap: msg=63, upper bits discarded
        got.delete();
        begin_ct(63);
        send(32'hFFFF_FC05); send(32'hFFFF_FC06); send(32'hFFFF_FC07); send(32'hFFFF_FC08);
        send(32'hFFFF_FFF0);
        wait_idle();
        chk("t3_n", 33'(got.size()), 33'd5);
        chk_out("t3_w0", 0, 0, 32'h005);
        chk_out("t3_w3", 3, 0, 32'h008);
        chk_out("t3_body", 4, 1, 32'h3E0);
        // overflow: push into a full FIFO drops the word
        got.delete();
        out_ready = 0;
        begin_ct(0);
        send(32'h21); send(32'h22); send(32'h23); send(32'h24);
        chk("t4_full_ready", 33'(in_ready), 33'd0);
        in_valid = 1;
        in_data = 32'h55;
        step();
        in_valid = 0;
        chk("t4_overflow", 33'(overflow), 33'd1);
        out_ready = 1;
        send(32'h99);
        wait_idle();
        chk("t4_n", 33'(got.size()), 33'd5);
        chk_out("t4_w3", 3, 0, 32'h24);
        chk_out("t4_body", 4, 1, 32'h99);
        // start during RUN is ignored; overflow stays sticky
        got.delete();
        begin_ct(3);
        send(32'h31);
        start = 1;
        msg = 9;
        step();
        start = 0;
        send(32'h32); send(32'h33); send(32'h34); send(32'h010);
        wait_idle();
        chk("t6_n", 33'(got.size()), 33'd5);
        chk_out("t6_w0", 0, 0, 32'h31);
        chk_out("t6_body", 4, 1, 32'h040);
        chk("t6_overflow", 33'(overflow), 33'd1);
        // async reset mid-RUN
        got.delete();
        out_ready = 0;
        begin_ct(0);
        send(32'h41); send(32'h42);
        #2 rst_n = 0;
        #1;
        chk("t5_out_valid", 33'(out_valid), 33'd0);
        chk("t5_busy", 33'(busy), 33'd0);
        chk("t5_in_ready", 33'(in_ready), 33'd0);
        chk("t5_overflow", 33'(overflow), 33'd0);
        rst_n = 1;
        step();
        out_ready = 1;
        begin_ct(1);
        send(1); send(2); send(3); send(4); send(32'h100);
        wait_idle();
        chk("t5_n", 33'(got.size()), 33'd5);
        chk_out("t5_w0", 0, 0, 32'h001);
        chk_out("t5_body", 4, 1, 32'h110);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
